rf_wb_arbiter: RTL

- Shares the single general-register write port between two writers: the pipeline WB stage and the multi-cycle mult/div unit (MDU) result return.
- Buffers MDU results in a small FIFO and keeps a busy scoreboard of GPRs with an MDU write outstanding; raises a hazard stall for decode when a read or destination register is busy.
- Guarantees MDU forward progress by briefly holding the pipeline WB stage.
- Sits between WB/MDU and the register file's write inputs (RegWrite, WriteReg, Write, LwMode, AddrLow2).

---
 rtl/rf_wb_arbiter_if.sv | 44 ++++
 rtl/rf_wb_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - WB/MDU/decode/register-file signal bundle for rf_wb_arbiter
interface rf_wb_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  wb_lwmode;
  logic [1:0]  wb_addrlow;
  logic        wb_hold;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_dst;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic [4:0]  chk_rd;
  logic        raw_stall;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [1:0]  rf_lwmode;
  logic [1:0]  rf_addrlow;

  modport slave (
    input  wb_we, wb_addr, wb_data, wb_lwmode, wb_addrlow,
    output wb_hold,
    input  mdu_issue, mdu_issue_dst, mdu_valid, mdu_addr, mdu_data,
    output mdu_ready,
    input  chk_rs, chk_rt, chk_rd,
    output raw_stall,
    output rf_we, rf_addr, rf_data, rf_lwmode, rf_addrlow
  );

  modport master (
    output wb_we, wb_addr, wb_data, wb_lwmode, wb_addrlow,
    input  wb_hold,
    output mdu_issue, mdu_issue_dst, mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready,
    output chk_rs, chk_rt, chk_rd,
    input  raw_stall,
    input  rf_we, rf_addr, rf_data, rf_lwmode, rf_addrlow
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter between WB stage and MDU result FIFO
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic           clk,
  input  logic           reset,
  rf_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [4:0]       fifoAddr [FIFO_DEPTH];
  logic [31:0]      fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr, wrPtr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starveCnt;
  logic [31:0]      busy, busyNext;
  logic             wbReq, headReq, forceHead, grantWb, grantHead;
  logic             push, pop, full;
  logic [4:0]       headAddr;
  logic [31:0]      headData;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign headReq   = (count != '0);
  assign headAddr  = fifoAddr[rdPtr];
  assign headData  = fifoData[rdPtr];
  assign wbReq     = bus.wb_we && (bus.wb_addr != 5'd0);
  assign forceHead = headReq && (starveCnt == STV_W'(MAX_WAIT));

  // Starved head pre-empts WB; otherwise WB has priority over buffered results.
  always_comb begin
    grantWb   = 1'b0;
    grantHead = 1'b0;
    if (!reset) begin
      if (forceHead)    grantHead = 1'b1;
      else if (wbReq)   grantWb   = 1'b1;
      else if (headReq) grantHead = 1'b1;
    end
  end

  assign pop  = grantHead;
  assign push = bus.mdu_valid && bus.mdu_ready;

  assign bus.mdu_ready  = !reset && !full;
  assign bus.wb_hold    = grantHead && wbReq;
  assign bus.rf_we      = grantWb || grantHead;
  assign bus.rf_addr    = grantHead ? headAddr : bus.wb_addr;
  assign bus.rf_data    = grantHead ? headData : bus.wb_data;
  assign bus.rf_lwmode  = grantHead ? 2'b00 : bus.wb_lwmode;
  assign bus.rf_addrlow = grantHead ? 2'b00 : bus.wb_addrlow;
  assign bus.raw_stall  = !reset && (busy[bus.chk_rs] || busy[bus.chk_rt] || busy[bus.chk_rd]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifoAddr[wrPtr] <= bus.mdu_addr;
      fifoData[wrPtr] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !headReq || pop)
      starveCnt <= '0;
    else if (starveCnt != STV_W'(MAX_WAIT))
      starveCnt <= starveCnt + 1'b1;
  end

  // A new issue to the register being retired this cycle keeps it busy.
  always_comb begin
    busyNext = busy;
    if (pop)           busyNext[headAddr]          = 1'b0;
    if (bus.mdu_issue) busyNext[bus.mdu_issue_dst] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busyNext;
  end
endmodule
